// File: rtl/proc_pkg.sv
// Shared constants for the processor pipeline: stage-register state encodings
// and the default datapath width.
package proc_pkg;

  localparam int XLEN = 32;

  typedef logic [1:0] pipe_state_t;

  localparam pipe_state_t PIPE_ST_EMPTY = 2'b00;
  localparam pipe_state_t PIPE_ST_BUSY  = 2'b01;
  localparam pipe_state_t PIPE_ST_FULL  = 2'b10;

endpackage

// File: rtl/proc_pipe_ctrl.sv
// Handshake controller for the 2-entry skid-buffer pipeline register.
// o_valid/o_ready are flops, so no combinational path crosses the stage.
module proc_pipe_ctrl
  import proc_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_flush,
  input  logic i_valid,
  input  logic i_ready,
  output logic o_valid,
  output logic o_ready,
  output logic load_main,
  output logic sel_skid,
  output logic load_skid
);

  pipe_state_t state_q;
  pipe_state_t state_next;
  logic        valid_q;
  logic        ready_q;
  logic        up_xfer;
  logic        dn_xfer;

  assign up_xfer = i_valid && ready_q;
  assign dn_xfer = valid_q && i_ready;

  always_comb begin
    state_next = state_q;
    load_main  = 1'b0;
    sel_skid   = 1'b0;
    load_skid  = 1'b0;
    case (state_q)
      PIPE_ST_EMPTY: begin
        if (up_xfer) begin
          load_main  = 1'b1;
          state_next = PIPE_ST_BUSY;
        end
      end
      PIPE_ST_BUSY: begin
        if (up_xfer && dn_xfer) begin
          load_main = 1'b1;
        end else if (up_xfer) begin
          load_skid  = 1'b1;
          state_next = PIPE_ST_FULL;
        end else if (dn_xfer) begin
          state_next = PIPE_ST_EMPTY;
        end
      end
      PIPE_ST_FULL: begin
        if (dn_xfer) begin
          load_main  = 1'b1;
          sel_skid   = 1'b1;
          state_next = PIPE_ST_BUSY;
        end
      end
      default: state_next = PIPE_ST_EMPTY;
    endcase
    // Squash wins over any same-cycle transfer; payload registers keep their contents.
    if (i_flush) begin
      state_next = PIPE_ST_EMPTY;
      load_main  = 1'b0;
      sel_skid   = 1'b0;
      load_skid  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PIPE_ST_EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_next;
      valid_q <= (state_next != PIPE_ST_EMPTY);
      ready_q <= (state_next != PIPE_ST_FULL);
    end
  end

  assign o_valid = valid_q;
  assign o_ready = ready_q;

endmodule

// File: rtl/proc_pipe_reg.sv
// Valid/ready pipeline-stage register with skid buffer and synchronous flush.
// Define PROC_PIPE_REG_STATS_EN to build the saturating stall-cycle counter.
module proc_pipe_reg
  import proc_pkg::*;
#(
  parameter int                    DATA_WIDTH = XLEN,
  parameter logic [DATA_WIDTH-1:0] RST_DATA   = {DATA_WIDTH{1'b0}},
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_flush,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [CNT_WIDTH-1:0]  o_stall_cnt
);

  logic                  load_main;
  logic                  sel_skid;
  logic                  load_skid;
  logic [DATA_WIDTH-1:0] main_q;
  logic [DATA_WIDTH-1:0] skid_q;
  logic [DATA_WIDTH-1:0] main_next;

  proc_pipe_ctrl u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .i_flush   (i_flush),
    .i_valid   (i_valid),
    .i_ready   (i_ready),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .load_main (load_main),
    .sel_skid  (sel_skid),
    .load_skid (load_skid)
  );

  assign main_next = sel_skid ? skid_q : i_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= RST_DATA;
      skid_q <= RST_DATA;
    end else begin
      if (load_main) main_q <= main_next;
      if (load_skid) skid_q <= i_data;
    end
  end

  assign o_data = main_q;

`ifdef PROC_PIPE_REG_STATS_EN
  logic [CNT_WIDTH-1:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (o_valid && !i_ready && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
`else
  assign o_stall_cnt = '0;
`endif

endmodule

// File: doc/proc_pipe_reg.md
Name: proc_pipe_reg

Overview:
- Parametrised pipeline-stage register for the RISC-V core, placed between stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Replaces the plain enable-gated register with a valid/ready handshake stage built on a 2-entry skid buffer.
- Also provides a synchronous flush and a registered (non-combinational) ready.
- Gives full throughput with no combinational ready path across stages, and lets branch/exception logic squash in-flight instructions.

Parameters:
- DATA_WIDTH, 32, payload width in bits.
- RST_DATA, {DATA_WIDTH{1'b0}}, reset value of both payload registers and of o_data.
- CNT_WIDTH, 16, width of the optional stall counter.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- i_flush  input  1  synchronous squash of all held entries.
- i_valid  input  1  upstream payload valid.
- o_ready  output  1  stage can accept; registered, decoded from state only.
- i_data  input  DATA_WIDTH  upstream payload.
- o_valid  output  1  downstream payload valid.
- i_ready  input  1  downstream accepts.
- o_data  output  DATA_WIDTH  downstream payload (main register).
- o_stall_cnt  output  CNT_WIDTH  saturating stall-cycle count (optional feature).

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Storage: main register (main_q, drives o_data) and skid register (skid_q). 2-bit state register.
- Handshakes:
  - Upstream transfer when i_valid && o_ready.
  - Downstream transfer when o_valid && i_ready.
  - o_valid = (state != EMPTY). o_ready = (state != FULL).
  - Neither output has a combinational dependence on i_valid or i_ready.
- States and transitions:
  - EMPTY:
    - Upstream transfer: main_q <= i_data, go to BUSY.
    - Otherwise stay.
  - BUSY:
    - Upstream and downstream transfer: main_q <= i_data, stay.
    - Upstream only: skid_q <= i_data, go to FULL.
    - Downstream only: go to EMPTY.
    - Neither: stay.
  - FULL:
    - o_ready = 0. i_data is ignored regardless of i_valid.
    - Downstream transfer: main_q <= skid_q, go to BUSY.
    - Otherwise stay.
- Latency and throughput:
  - 1 cycle input-to-output latency: i_data appears on o_data the cycle after the upstream transfer.
  - Sustained throughput 1 item per cycle while i_ready is held high.
  - Ordering is strictly FIFO.
- Flush:
  - i_flush = 1 forces the state to EMPTY next cycle.
  - Flush has priority over any same-cycle upstream transfer; that input item is dropped and the producer sees o_ready as its state-decoded value.
  - Payload registers are not cleared by flush.
- Reset:
  - rst has priority over flush and all transfers.
  - Next cycle: state = EMPTY, o_valid = 0, o_ready = 1, main_q = skid_q = o_data = RST_DATA, o_stall_cnt = 0.
  - Reset mid-operation discards both entries.
- Payload registers load only on the transitions listed above; otherwise they hold.
- The illegal state value (2'b11) recovers to EMPTY on the next clock.

Optional Feature:
- Macro: PROC_PIPE_REG_STATS_EN.
- Defined:
  - o_stall_cnt increments by 1 in every cycle where o_valid && !i_ready.
  - Saturates at all-ones (2^CNT_WIDTH-1) and does not wrap.
  - Cleared only by rst; flush does not clear it.
- Not defined:
  - No counter logic is synthesised; o_stall_cnt is tied to 0.
  - The port list is identical in both builds.

Decomposition:
- Shared package proc_pkg:
  - State encodings as localparams: PIPE_ST_EMPTY = 2'b00, PIPE_ST_BUSY = 2'b01, PIPE_ST_FULL = 2'b10.
  - Default DATA_WIDTH constant XLEN = 32.
- One natural sub-module, proc_pipe_ctrl:
  - Contains the state machine.
  - Produces o_valid, o_ready, load_main, sel_skid and load_skid.
  - The top-level module holds main_q, skid_q, the output mux and the optional counter.

Test Plan:
- Reset: assert rst for 2 cycles with i_valid = 1, i_data = 32'hDEAD_BEEF → o_valid = 0, o_ready = 1, o_data = 0, o_stall_cnt = 0; no item enters.
- Streaming: i_ready = 1, send 32'h1, 32'h2, 32'h3 on consecutive cycles → o_data = 1, 2, 3 on the following three cycles; o_ready stays 1.
- Backpressure: i_ready = 0, send 32'hA then 32'hB → state FULL, o_ready = 0, o_data = A. 32'hC offered while FULL is not accepted. Raise i_ready → outputs A then B, o_ready returns to 1 one cycle after A is consumed.
- Flush:
  - FULL holding A and B, assert i_flush with i_valid = 1, i_data = 32'hC → next cycle o_valid = 0, o_ready = 1, C is dropped.
  - Next item 32'hD emerges alone.
- Stats (macro defined): hold o_valid with i_ready = 0 for 10 cycles → o_stall_cnt = 10. With CNT_WIDTH = 3 and 12 stall cycles → o_stall_cnt = 7.
- Stats (macro undefined): same stall stimulus → o_stall_cnt = 0.
